// File: rtl/fc_stream_arbiter.sv
// fc_stream_arbiter: lends one shared fc accelerator to two requesters, one whole vector job at a time.
// Ports: clk/reset (sync, active-high); in0/in1 request streams; out0/out1 result streams;
//        acc_input/acc_output accelerator streams; grant = owning requester, busy = job in flight,
//        done0/done1 = one-cycle end-of-job pulses.
module fc_stream_arbiter #(
   parameter int WIDTH = 12,
   parameter int N = 6,
   parameter int M = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in0_valid,
   output logic                    in0_ready,
   input  logic signed [WIDTH-1:0] in0_data,
   input  logic                    in1_valid,
   output logic                    in1_ready,
   input  logic signed [WIDTH-1:0] in1_data,
   output logic                    out0_valid,
   input  logic                    out0_ready,
   output logic signed [WIDTH-1:0] out0_data,
   output logic                    out1_valid,
   input  logic                    out1_ready,
   output logic signed [WIDTH-1:0] out1_data,
   output logic                    acc_input_valid,
   input  logic                    acc_input_ready,
   output logic signed [WIDTH-1:0] acc_input_data,
   input  logic                    acc_output_valid,
   output logic                    acc_output_ready,
   input  logic signed [WIDTH-1:0] acc_output_data,
   output logic                    grant,
   output logic                    busy,
   output logic                    done0,
   output logic                    done1
);
   localparam int IW = $clog2(N + 1);
   localparam int OW = $clog2(M + 1);
   typedef enum logic [1:0] {IDLE, LOAD, COLLECT} state_t;
   state_t state, state_nx;
   logic grant_nx, prio, in_hs, out_hs, in_last, out_last;
   logic [IW-1:0] in_cnt;
   logic [OW-1:0] out_cnt;
   // Handshakes are derived from inputs directly so they never loop back through the output muxes.
   assign in_hs    = (state == LOAD) & acc_input_ready & (grant ? in1_valid : in0_valid);
   assign out_hs   = (state == COLLECT) & acc_output_valid & (grant ? out1_ready : out0_ready);
   assign in_last  = in_cnt == IW'(N - 1);
   assign out_last = out_cnt == OW'(M - 1);
   assign busy     = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         prio    <= 1'b0;
         grant   <= 1'b0;
         in_cnt  <= '0;
         out_cnt <= '0;
         done0   <= 1'b0;
         done1   <= 1'b0;
      end else begin
         state   <= state_nx;
         grant   <= grant_nx;
         in_cnt  <= in_hs ? (in_last ? '0 : in_cnt + 1'b1) : in_cnt;
         out_cnt <= out_hs ? (out_last ? '0 : out_cnt + 1'b1) : out_cnt;
         done0   <= out_hs & out_last & ~grant;
         done1   <= out_hs & out_last & grant;
         if (out_hs & out_last) prio <= ~grant;
      end
   end
   always_comb begin
      state_nx         = state;
      grant_nx         = grant;
      in0_ready        = 1'b0;
      in1_ready        = 1'b0;
      out0_valid       = 1'b0;
      out1_valid       = 1'b0;
      out0_data        = '0;
      out1_data        = '0;
      acc_input_valid  = 1'b0;
      acc_input_data   = '0;
      acc_output_ready = 1'b0;
      case (state)
         IDLE: if (in0_valid | in1_valid) begin
            state_nx = LOAD;
            grant_nx = (in0_valid & in1_valid) ? prio : in1_valid;
         end
         LOAD: begin
            acc_input_valid = grant ? in1_valid : in0_valid;
            acc_input_data  = grant ? in1_data : in0_data;
            in0_ready       = ~grant & acc_input_ready;
            in1_ready       = grant & acc_input_ready;
            if (in_hs & in_last) state_nx = COLLECT;
         end
         COLLECT: begin
            out0_valid       = ~grant & acc_output_valid;
            out1_valid       = grant & acc_output_valid;
            out0_data        = grant ? '0 : acc_output_data;
            out1_data        = grant ? acc_output_data : '0;
            acc_output_ready = grant ? out1_ready : out0_ready;
            if (out_hs & out_last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_fc_stream_arbiter.sv
// tb_fc_stream_arbiter: directed bench for fc_stream_arbiter; the bench plays both requesters, both
// result consumers and the accelerator.
module tb_fc_stream_arbiter;
   localparam int WIDTH = 12;
   localparam int N = 6;
   localparam int M = 6;
   logic clk = 1'b0;
   logic reset;
   logic in0_valid, in0_ready, in1_valid, in1_ready;
   logic out0_valid, out0_ready, out1_valid, out1_ready;
   logic acc_input_valid, acc_input_ready, acc_output_valid, acc_output_ready;
   logic signed [WIDTH-1:0] in0_data, in1_data, out0_data, out1_data, acc_input_data, acc_output_data;
   logic grant, busy, done0, done1;
   int passed = 0;
   int total = 0;

   fc_stream_arbiter #(.WIDTH(WIDTH), .N(N), .M(M)) dut (
      .clk(clk), .reset(reset),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
      .acc_input_valid(acc_input_valid), .acc_input_ready(acc_input_ready), .acc_input_data(acc_input_data),
      .acc_output_valid(acc_output_valid), .acc_output_ready(acc_output_ready), .acc_output_data(acc_output_data),
      .grant(grant), .busy(busy), .done0(done0), .done1(done1)
   );

   always #5 clk = ~clk;

   task automatic quiet();
      in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0;
      out0_ready = 0; out1_ready = 0;
      acc_input_ready = 0; acc_output_valid = 0; acc_output_data = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      quiet();
      reset = 1;
      @(negedge clk);
      reset = 0;
   endtask

   // Drives the grant cycle (caller guarantees the DUT is idle right now) and then N load words.
   task automatic load_phase(input bit req, input bit other_v, input bit rnd, input bit spur, input int base);
      int k = 0;
      int n = 0;
      logic signed [WIDTH-1:0] exp;
      in0_valid = req ? other_v : 1'b1;
      in1_valid = req ? 1'b1 : other_v;
      in0_data = req ? 12'sh2AA : '0;
      in1_data = req ? '0 : 12'sh2AA;
      acc_input_ready = 1; acc_output_valid = spur; acc_output_data = 12'sh155;
      out0_ready = 1; out1_ready = 1;
      #1;
      total++;
      if ({busy, acc_input_valid, in0_ready, in1_ready, acc_output_ready, out0_valid, out1_valid} !== 7'b0) begin
         $display("FAIL grant_cycle got %b exp 0000000", {busy, acc_input_valid, in0_ready, in1_ready, acc_output_ready, out0_valid, out1_valid});
      end else passed++;
      while (k < N && n < 200) begin
         @(negedge clk);
         exp = WIDTH'(base + k);
         if (req) in1_data = exp; else in0_data = exp;
         acc_input_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         total++;
         if ({grant, busy} !== {req, 1'b1}) $display("FAIL load_grant got %b exp %b", {grant, busy}, {req, 1'b1});
         else passed++;
         total++;
         if (acc_input_valid !== 1'b1 || acc_input_data !== exp)
            $display("FAIL load_data got v=%b d=%0d exp v=1 d=%0d", acc_input_valid, acc_input_data, exp);
         else passed++;
         total++;
         if ({in0_ready, in1_ready} !== {~req & acc_input_ready, req & acc_input_ready})
            $display("FAIL load_ready got %b exp %b", {in0_ready, in1_ready}, {~req & acc_input_ready, req & acc_input_ready});
         else passed++;
         total++;
         if ({acc_output_ready, out0_valid, out1_valid, done0, done1} !== 5'b0)
            $display("FAIL load_hold got %b exp 00000", {acc_output_ready, out0_valid, out1_valid, done0, done1});
         else passed++;
         if (acc_input_ready) k++;
         n++;
      end
      total++;
      if (k != N) $display("FAIL load_timeout got %0d words exp %0d", k, N);
      else passed++;
   endtask

   // Feeds M results from the accelerator side; the granted consumer stalls for the first `stall` cycles.
   task automatic collect_phase(input bit req, input int stall, input int base, input bit in0v, input bit in1v);
      int k = 0;
      int n = 0;
      logic signed [WIDTH-1:0] exp;
      while (k < M && n < 200) begin
         @(negedge clk);
         in0_valid = in0v; in1_valid = in1v;
         exp = WIDTH'(base + k);
         acc_output_valid = 1; acc_output_data = exp; acc_input_ready = 1;
         out0_ready = req ? 1'b1 : (n >= stall);
         out1_ready = req ? (n >= stall) : 1'b1;
         #1;
         total++;
         if ({out0_valid, out1_valid} !== {~req, req}) $display("FAIL coll_valid got %b exp %b", {out0_valid, out1_valid}, {~req, req});
         else passed++;
         total++;
         if ((req ? out1_data : out0_data) !== exp || (req ? out0_data : out1_data) !== '0)
            $display("FAIL coll_data got out0=%0d out1=%0d exp %0d on out%0d", out0_data, out1_data, exp, req);
         else passed++;
         total++;
         if (acc_output_ready !== (req ? out1_ready : out0_ready))
            $display("FAIL coll_ready got %b exp %b", acc_output_ready, req ? out1_ready : out0_ready);
         else passed++;
         total++;
         if ({acc_input_valid, in0_ready, in1_ready, done0, done1, busy} !== 6'b000001)
            $display("FAIL coll_hold got %b exp 000001", {acc_input_valid, in0_ready, in1_ready, done0, done1, busy});
         else passed++;
         if (req ? out1_ready : out0_ready) k++;
         n++;
      end
      total++;
      if (k != M) $display("FAIL coll_timeout got %0d results exp %0d", k, M);
      else passed++;
      @(negedge clk);
      acc_output_valid = 0; out0_ready = 0; out1_ready = 0;
      #1;
      total++;
      if ({done0, done1, busy, out0_valid, out1_valid} !== {~req, req, 3'b000})
         $display("FAIL done_pulse got %b exp %b", {done0, done1, busy, out0_valid, out1_valid}, {~req, req, 3'b000});
      else passed++;
   endtask

   task automatic check_no_done(input string name);
      @(negedge clk);
      #1;
      total++;
      if ({done0, done1} !== 2'b00) $display("FAIL %s got done=%b exp 00", name, {done0, done1});
      else passed++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1;
      in0_valid = 1; in1_valid = 1; in0_data = 12'sd5; in1_data = 12'sd9;
      acc_input_ready = 1; acc_output_valid = 1; acc_output_data = 12'sd3;
      out0_ready = 1; out1_ready = 1;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if ({busy, grant, done0, done1} !== 4'b0) $display("FAIL reset_state got %b exp 0000", {busy, grant, done0, done1});
      else passed++;
      total++;
      if ({in0_ready, in1_ready, out0_valid, out1_valid, acc_input_valid, acc_output_ready} !== 6'b0)
         $display("FAIL reset_handshake got %b exp 000000", {in0_ready, in1_ready, out0_valid, out1_valid, acc_input_valid, acc_output_ready});
      else passed++;
      total++;
      if ({acc_input_data, out0_data, out1_data} !== '0)
         $display("FAIL reset_data got %h %h %h exp 0", acc_input_data, out0_data, out1_data);
      else passed++;
      @(negedge clk);
      quiet();
      reset = 0;
   endtask

   task automatic test_single();
      load_phase(0, 0, 0, 0, 1);
      collect_phase(0, 0, 101, 0, 0);
      check_no_done("single_done_once");
   endtask

   task automatic test_load_backpressure();
      load_phase(0, 0, 1, 0, -20);
      collect_phase(0, 0, 200, 0, 0);
   endtask

   task automatic test_collect_backpressure();
      load_phase(1, 0, 0, 0, 30);
      collect_phase(1, 10, -300, 0, 0);
      check_no_done("stall_done_once");
   endtask

   task automatic test_spurious_output();
      load_phase(0, 0, 0, 1, 7);
      collect_phase(0, 0, 77, 0, 0);
   endtask

   task automatic test_reset_midjob();
      in0_valid = 1; in0_data = 12'sd60; acc_input_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in0_data = WIDTH'(60 + i);
      end
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      in0_valid = 0;
      #1;
      total++;
      if ({busy, grant, acc_input_valid, in0_ready, done0, done1} !== 6'b0)
         $display("FAIL midjob_reset got %b exp 000000", {busy, grant, acc_input_valid, in0_ready, done0, done1});
      else passed++;
      check_no_done("midjob_no_done");
      load_phase(0, 0, 0, 0, 50);
      collect_phase(0, 0, 500, 0, 0);
   endtask

   task automatic test_both();
      apply_reset();
      load_phase(0, 1, 0, 0, 1);
      collect_phase(0, 0, 11, 1, 1);
      load_phase(1, 1, 0, 0, 21);
      collect_phase(1, 0, 31, 0, 0);
      check_no_done("both_done_once");
   endtask

   initial begin
      reset = 1;
      quiet();
      test_reset();
      test_single();
      test_load_backpressure();
      test_collect_backpressure();
      test_spurious_output();
      test_reset_midjob();
      test_both();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fc_stream_arbiter.md
FC_STREAM_ARBITER -- requirements
Module: fc_stream_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12: data word width, signed.
REQ-002 The block SHALL have parameter N, default 6: input words per vector job.
REQ-003 The block SHALL have parameter M, default 6: output words per vector job.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports in0_valid (input, 1), in0_ready (output, 1) and in0_data (input, WIDTH): requester 0 input stream.
REQ-007 The block SHALL have ports in1_valid (input, 1), in1_ready (output, 1) and in1_data (input, WIDTH): requester 1 input stream.
REQ-008 The block SHALL have ports out0_valid (output, 1), out0_ready (input, 1) and out0_data (output, WIDTH): requester 0 result stream.
REQ-009 The block SHALL have ports out1_valid (output, 1), out1_ready (input, 1) and out1_data (output, WIDTH): requester 1 result stream.
REQ-010 The block SHALL have ports acc_input_valid (output, 1), acc_input_ready (input, 1) and acc_input_data (output, WIDTH): stream to the shared fc accelerator.
REQ-011 The block SHALL have ports acc_output_valid (input, 1), acc_output_ready (output, 1) and acc_output_data (input, WIDTH): stream from the shared fc accelerator.
REQ-012 The block SHALL have ports grant (output, 1: owning requester), busy (output, 1: high in LOAD/COLLECT) and done0/done1 (output, 1 each: one-cycle pulse when that requester's job ends).

Function
REQ-013 The block SHALL implement the FSM states IDLE, LOAD and COLLECT, plus a 1-bit priority pointer prio.
REQ-014 In IDLE: if only inX_valid=1, the FSM SHALL register grant=X and go to LOAD next cycle.
REQ-015 In IDLE: if both valid, grant SHALL be prio; if neither, the FSM SHALL stay in IDLE.
REQ-016 In IDLE, all *_ready and *_valid outputs SHALL be 0, so no word is consumed in the grant cycle.
REQ-017 In LOAD: acc_input_valid SHALL equal in[grant]_valid; acc_input_data SHALL equal in[grant]_data; in[grant]_ready SHALL equal acc_input_ready; the other in_ready SHALL be 0; all of this combinational.
REQ-018 In LOAD, the block SHALL count handshakes (valid and ready both 1) in in_cnt, width $clog2(N+1).
REQ-019 On the N-th LOAD handshake, the block SHALL clear in_cnt and enter COLLECT next cycle.
REQ-020 In LOAD, acc_output_ready SHALL be 0: stray accelerator output is held off, not dropped.
REQ-021 In COLLECT: out[grant]_valid SHALL equal acc_output_valid; out[grant]_data SHALL equal acc_output_data; acc_output_ready SHALL equal out[grant]_ready; the other out_valid SHALL be 0; acc_input_valid SHALL be 0.
REQ-022 In COLLECT, the block SHALL count output handshakes in out_cnt, width $clog2(M+1).
REQ-023 On the M-th COLLECT handshake: out_cnt SHALL clear; done[grant] SHALL pulse the next cycle; prio SHALL become ~grant; the FSM SHALL return to IDLE.
REQ-024 The block SHALL start a new job only after the previous job's M results are drained: at most one job in flight.
REQ-025 Non-granted data outputs SHALL be driven 0.
REQ-026 Backpressure on either side SHALL stall the counters without loss or duplication of words.
REQ-027 The minimum job length SHALL be 1 + N + M cycles plus the accelerator's latency.
REQ-028 Counter wrap SHALL NOT occur: each counter is cleared exactly at its terminal count.

Reset
REQ-029 When reset=1 at a posedge, the block SHALL set state=IDLE, prio=0, grant=0 and in_cnt=out_cnt=0.
REQ-030 When reset=1 at a posedge, the block SHALL set done0=done1=0 and busy=0.
REQ-031 When reset=1, all ready/valid outputs SHALL be 0 in the following cycle.
REQ-032 Reset mid-job SHALL abandon the job with no done pulse; the accelerator is reset by the same reset.
REQ-033 Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-034 The bench SHALL drive, after reset, in0_valid=1 alone with 6 words (1..6) -> grant=0, 6 words passed to acc_input in order, 6 results routed to out0 only, done0 pulses once, prio=1.
REQ-035 The bench SHALL drive both requesters valid in IDLE right after reset -> requester 0 served first; then requester 1 is served even if in0_valid stays 1.
REQ-036 The bench SHALL toggle acc_input_ready randomly (50%) during LOAD -> exactly 6 handshakes; in0_ready mirrors acc_input_ready; no duplicated word.
REQ-037 The bench SHALL hold out1_ready=0 for 10 cycles in COLLECT -> acc_output_ready=0 and out1_valid held; no results lost; done1 only after 6th handshake.
REQ-038 The bench SHALL assert reset after 3 of 6 LOAD words -> next cycle state=IDLE, busy=0, no done pulse; a fresh job then completes normally.
REQ-039 The bench SHALL assert acc_output_valid spuriously during LOAD -> acc_output_ready=0, out0_valid=out1_valid=0.
